// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: multicycle MULT/DIV, MTHI/MTLO writes, HI/LO holding registers.
// Optional feature macro: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
module ex_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [31:0]       rs_q;
  logic [31:0]       rt_q;

  logic              is_mul_c;
  logic              is_div_c;
  logic              is_mthi_c;
  logic              is_mtlo_c;
  logic              accept_c;

  logic signed [63:0] a64_s;
  logic signed [63:0] b64_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] rs_s;
  logic signed [31:0] div_bs;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] div_bu;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic              div_ovf_c;
  logic [63:0]       res_c;
  logic              commit_en_c;

  // Decode the issuing op; unused and disabled codes fall through as NOP
  always_comb begin
    is_mul_c  = 1'b0;
    is_div_c  = 1'b0;
    is_mthi_c = 1'b0;
    is_mtlo_c = 1'b0;
    case (mdu_op)
      OP_MULT, OP_MULTU: is_mul_c  = 1'b1;
      OP_DIV, OP_DIVU:   is_div_c  = 1'b1;
      OP_MTHI:           is_mthi_c = 1'b1;
      OP_MTLO:           is_mtlo_c = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_c = 1'b1;
`endif
      default: ;
    endcase
  end

  assign accept_c = start && !req && !busy;

  // Arithmetic on the latched operands; divisor is forced to 1 for /0 (not committed)
  // and for the signed overflow case, where x/1 yields exactly quotient=x, remainder=0
  always_comb begin
    a64_s     = {{32{rs_q[31]}}, rs_q};
    b64_s     = {{32{rt_q[31]}}, rt_q};
    prod_s    = a64_s * b64_s;
    prod_u    = {32'd0, rs_q} * {32'd0, rt_q};
    div_ovf_c = (rs_q == 32'h8000_0000) && (rt_q == 32'hFFFF_FFFF);
    rs_s      = rs_q;
    div_bs    = ((rt_q == 32'd0) || div_ovf_c) ? 32'sd1 : rt_q;
    quot_s    = rs_s / div_bs;
    rem_s     = rs_s % div_bs;
    div_bu    = (rt_q == 32'd0) ? 32'd1 : rt_q;
    quot_u    = rs_q / div_bu;
    rem_u     = rs_q % div_bu;
  end

  // Select the commit value for the in-flight op
  always_comb begin
    res_c       = {hi, lo};
    commit_en_c = 1'b1;
    case (op_q)
      OP_MULT:  res_c = prod_s;
      OP_MULTU: res_c = prod_u;
      OP_DIV: begin
        if (rt_q == 32'd0) commit_en_c = 1'b0;
        else               res_c = {rem_s, quot_s};
      end
      OP_DIVU: begin
        if (rt_q == 32'd0) commit_en_c = 1'b0;
        else               res_c = {rem_u, quot_u};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res_c = {hi, lo} + prod_s;
      OP_MADDU: res_c = {hi, lo} + prod_u;
      OP_MSUB:  res_c = {hi, lo} - prod_s;
      OP_MSUBU: res_c = {hi, lo} - prod_u;
`endif
      default:  commit_en_c = 1'b0;
    endcase
  end

  // Issue, countdown and commit; busy mirrors cnt != 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= 4'd0;
      rs_q <= 32'd0;
      rt_q <= 32'd0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        if (commit_en_c) begin
          hi <= res_c[63:32];
          lo <= res_c[31:0];
        end
      end
    end else if (accept_c) begin
      if (is_mthi_c) hi <= rs;
      if (is_mtlo_c) lo <= rs;
      if (is_mul_c || is_div_c) begin
        op_q <= mdu_op;
        rs_q <= rs;
        rt_q <= rt;
        cnt  <= is_mul_c ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu (default parameters; MDU_MADD_EN optional).
module tb_ex_mdu;

  logic        clk;
  logic        reset;
  logic        req;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  ex_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .start  (start),
    .mdu_op (mdu_op),
    .rs     (rs),
    .rt     (rt),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for one rising edge, then scramble the operand inputs
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs = a; rt = b; req = r;
    @(posedge clk);
    #1;
    start = 1'b0; mdu_op = 4'd0; req = 1'b0;
    rs = 32'hDEAD_BEEF; rt = 32'h0BAD_F00D;
  endtask

  // Count negedges with busy high (bounded at 64)
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; start = 1'b0; mdu_op = 4'd0; rs = 32'd0; rt = 32'd0;
    #12;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 64'd0}) begin
      miscompares++;
      $display("FAIL reset: busy=%0b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi: hi=%h busy=%0b, want 12345678/0", hi, busy);
    end
    issue(4'd6, 32'hCAFE_0001, 32'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (lo !== 32'hCAFE_0001 || hi !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL mtlo: hi=%h lo=%h, want 12345678/cafe0001", hi, lo);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'd3, 32'hFFFF_FFFC, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL mult_busy: cycles=%0d, want 5", n);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF4) begin
      miscompares++;
      $display("FAIL mult: hi=%h lo=%h, want ffffffff/fffffff4", hi, lo);
    end
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    vectors++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL multu: hi=%h lo=%h, want fffffffe/00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 10) begin
      miscompares++;
      $display("FAIL div_busy: cycles=%0d, want 10", n);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      miscompares++;
      $display("FAIL div_signed: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
    end
    issue(4'd4, 32'd7, 32'd2, 1'b0);
    wait_idle(n);
    vectors++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      miscompares++;
      $display("FAIL divu: hi=%h lo=%h, want 1/3", hi, lo);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL div_ovf: hi=%h lo=%h, want 0/80000000", hi, lo);
    end
    issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    vectors++;
    if (hi !== 32'h8000_0000 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL divu_big: hi=%h lo=%h, want 80000000/0", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(4'd5, 32'h0000_000A, 32'd0, 1'b0);
    issue(4'd6, 32'h0000_000B, 32'd0, 1'b0);
    issue(4'd4, 32'd5, 32'd0, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 10) begin
      miscompares++;
      $display("FAIL div0_busy: cycles=%0d, want 10", n);
    end
    vectors++;
    if (hi !== 32'hA || lo !== 32'hB) begin
      miscompares++;
      $display("FAIL div0_hold: hi=%h lo=%h, want a/b", hi, lo);
    end
  endtask

  task automatic test_ignored();
    int n;
    issue(4'd2, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
      miscompares++;
      $display("FAIL req_block: busy=%0b hi=%h lo=%h, want 0/a/b", busy, hi, lo);
    end
    issue(4'd5, 32'h7777_7777, 32'd0, 1'b1);
    @(negedge clk);
    vectors++;
    if (hi !== 32'hA) begin
      miscompares++;
      $display("FAIL req_mthi: hi=%h, want a", hi);
    end
    issue(4'd7, 32'd4, 32'd4, 1'b0);
    @(negedge clk);
`ifndef MDU_MADD_EN
    vectors++;
    if (busy !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
      miscompares++;
      $display("FAIL madd_nop: busy=%0b hi=%h lo=%h, want 0/a/b", busy, hi, lo);
    end
`endif
    wait_idle(n);
    issue(4'd12, 32'd4, 32'd4, 1'b0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL op12_nop: busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'd1, 32'd6, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd3; rs = 32'd100; rt = 32'd3; req = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mdu_op = 4'd0; req = 1'b0;
    wait_idle(n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL b2b_busy: remaining=%0d, want 4", n);
    end
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      miscompares++;
      $display("FAIL b2b_result: hi=%h lo=%h, want 0/2a", hi, lo);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_div: busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    issue(4'd5, 32'h55, 32'd0, 1'b0);
    issue(4'd6, 32'h66, 32'd0, 1'b0);
    issue(4'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_abort: busy=%0b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_nocommit: busy=%0b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    int n;
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'd1, 32'd0, 1'b0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 5 || hi !== 32'd1 || lo !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL maddu: cycles=%0d hi=%h lo=%h, want 5/1/ffffffff", n, hi, lo);
    end
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_idle(n);
    vectors++;
    if (hi !== 32'd2 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL msub: hi=%h lo=%h, want 2/0", hi, lo);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored();
    test_back_to_back();
    test_reset_abort();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
